button_event_parser: RTL and testbench

// - Consumer of the debouncer's debounced_signal bus. Turns clean per-button levels into single-cycle

---
 rtl/button_pkg.sv | 19 +
 rtl/button_event_fsm.sv | 120 ++++++++++++
 rtl/button_event_parser.sv | 62 ++++++
 tb/tb_button_event_parser.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the button event parser: FSM state encoding and counter widths.
// Latency: n/a. No backpressure: definitions only.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    HOLD    = 2'd3
  } btn_state_t;

  // Bits needed to hold 0..max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_event_fsm.sv
// One button: edge detect plus press/long/repeat hold FSM driven by a shared tick.
// Latency: 1 cycle from sampled level to pulse. No backpressure: pulses are fire-and-forget.
module button_event_fsm
  import button_pkg::*;
#(
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held,
  output logic long_held
);

  localparam int CW = cnt_width(LONG_TICKS, REPEAT_TICKS);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          prev_q, prev_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          rise, fall;

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    prev_d     = level;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    // Release wins over a coincident tick, so no long/repeat fires on the release cycle.
    if (state_q != IDLE && fall) begin
      release_d  = 1'b1;
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d    = 1'b1;
            state_d    = PRESSED;
            hold_cnt_d = '0;
          end
        end
        PRESSED: begin
          if (tick) begin
            if (hold_cnt_q == LONG_LAST) begin
              long_d     = 1'b1;
              hold_cnt_d = '0;
              state_d    = (REPEAT_EN != 0) ? LONG : HOLD;
            end else begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end
          end
        end
        LONG: begin
          if (tick) begin
            if (hold_cnt_q == REP_LAST) begin
              repeat_d   = (REPEAT_EN != 0);
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      prev_q     <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      prev_q     <= prev_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = (state_q != IDLE);
  assign long_held     = (state_q == LONG) || (state_q == HOLD);

endmodule

// File: rtl/button_event_parser.sv
// Turns debounced button levels into press/release/long/repeat pulses; one shared hold-timing prescaler.
// Latency: 1 cycle from sampled level to pulse. No backpressure: pulses are fire-and-forget.
module button_event_parser
  import button_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int TICK_CNT_MAX = 125000,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int REPEAT_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] button_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] repeat_pulse,
  output logic [WIDTH-1:0] held,
  output logic [WIDTH-1:0] long_held
);

  localparam int TW = cnt_width(TICK_CNT_MAX, 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT_MAX - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
    button_event_fsm #(
      .LONG_TICKS  (LONG_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .level        (button_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .held         (held[i]),
      .long_held    (long_held[i])
    );
  end

endmodule

// File: tb/tb_button_event_parser.sv
// Directed bench for button_event_parser: a 2-button repeat-enabled instance and a 1-button no-repeat instance.
module tb_button_event_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lvl_a;
  logic [1:0] press_a, rel_a, long_a, rep_a, held_a, lheld_a;
  logic [0:0] lvl_b;
  logic [0:0] press_b, rel_b, long_b, rep_b, held_b, lheld_b;

  always #5 clk = ~clk;

  button_event_parser #(
    .WIDTH(2), .TICK_CNT_MAX(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(1)
  ) dut_a (
    .clk(clk), .rst(rst), .button_level(lvl_a),
    .press_pulse(press_a), .release_pulse(rel_a), .long_pulse(long_a),
    .repeat_pulse(rep_a), .held(held_a), .long_held(lheld_a)
  );

  button_event_parser #(
    .WIDTH(1), .TICK_CNT_MAX(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .REPEAT_EN(0)
  ) dut_b (
    .clk(clk), .rst(rst), .button_level(lvl_b),
    .press_pulse(press_b), .release_pulse(rel_b), .long_pulse(long_b),
    .repeat_pulse(rep_b), .held(held_b), .long_held(lheld_b)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pc = 0;   // bench copy of the prescaler count after each edge
  int np[2], nr[2], nl[2], nrp[2];
  int held0, press_cyc, long_cyc, last_rep, bad_space;
  int nlb, nrpb, nrb;
  int lat, exp_rep, ticks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic clr();
    for (int b = 0; b < 2; b++) begin
      np[b] = 0; nr[b] = 0; nl[b] = 0; nrp[b] = 0;
    end
    held0 = 0; press_cyc = 0; long_cyc = 0; last_rep = 0; bad_space = 0;
    nlb = 0; nrpb = 0; nrb = 0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      pc = rst ? 0 : ((pc == 3) ? 0 : pc + 1);
      #1;
      cyc++;
      for (int b = 0; b < 2; b++) begin
        np[b]  += int'(press_a[b]);
        nr[b]  += int'(rel_a[b]);
        nl[b]  += int'(long_a[b]);
        nrp[b] += int'(rep_a[b]);
      end
      if (press_a[0]) press_cyc = cyc;
      if (long_a[0]) long_cyc = cyc;
      if (rep_a[0]) begin
        if (cyc - ((nrp[0] == 1) ? long_cyc : last_rep) != 8) bad_space++;
        last_rep = cyc;
      end
      held0 += int'(held_a[0]);
      nlb   += int'(long_b[0]);
      nrpb  += int'(rep_b[0]);
      nrb   += int'(rel_b[0]);
    end
  endtask

  // Press bit0, then stop right before the posedge that carries the third tick since the press.
  task automatic press_to_third_tick();
    lvl_a[0] = 1'b1;
    step(1);
    ticks = 0;
    for (int g = 0; g < 40; g++) begin
      if (pc == 3) begin
        if (ticks == 2) break;
        ticks++;
      end
      step(1);
    end
  endtask

  initial begin
    rst = 1'b1; lvl_a = 2'b00; lvl_b = 1'b0;
    clr();
    step(3);
    check("reset_outputs_a", {press_a, rel_a, long_a, rep_a, held_a, lheld_a}, 0);
    check("reset_outputs_b", {press_b, rel_b, long_b, rep_b, held_b, lheld_b}, 0);
    rst = 1'b0;
    step(2);

    // Short press: 6 cycles high
    clr();
    lvl_a = 2'b01; step(6);
    lvl_a = 2'b00; step(3);
    check("short_press_cnt", np[0], 1);
    check("short_release_cnt", nr[0], 1);
    check("short_long_cnt", nl[0] + nrp[0], 0);
    check("short_held_cycles", held0, 6);

    // Long hold: 60 cycles high
    clr();
    lvl_a = 2'b01; step(60);
    check("long_lheld_before_rel", lheld_a[0], 1);
    lvl_a = 2'b00; step(1);
    check("long_release_pulse", rel_a[0], 1);
    check("long_lheld_after_rel", {held_a[0], lheld_a[0]}, 0);
    step(5);
    lat = long_cyc - press_cyc;
    exp_rep = (59 - lat) / 8;
    check("long_cnt", nl[0], 1);
    check("long_latency_in_9_12", (lat >= 9 && lat <= 12), 1);
    check("long_repeat_cnt", nrp[0], exp_rep);
    check("long_repeat_max6", (nrp[0] <= 6), 1);
    check("long_repeat_spacing_bad", bad_space, 0);
    check("long_release_cnt", nr[0], 1);

    // Release exactly on the tick that would fire long_pulse
    clr();
    press_to_third_tick();
    lvl_a[0] = 1'b0; step(1);
    check("reltick_release_pulse", rel_a[0], 1);
    step(4);
    check("reltick_long_cnt", nl[0], 0);

    // Same, released one cycle later: long fires once
    clr();
    press_to_third_tick();
    step(1);
    lvl_a[0] = 1'b0; step(5);
    check("rellate_long_cnt", nl[0], 1);
    check("rellate_release_cnt", nr[0], 1);

    // Both bits rise together; bit1 short, bit0 held 40
    clr();
    lvl_a = 2'b11; step(1);
    check("both_press_pulse", press_a, 2'b11);
    step(3);
    lvl_a = 2'b01; step(1);
    check("both_release_bit1_only", rel_a, 2'b10);
    step(35);
    lvl_a = 2'b00; step(3);
    lat = long_cyc - press_cyc;
    exp_rep = (39 - lat) / 8;
    check("both_bit1_long_cnt", nl[1] + nrp[1], 0);
    check("both_bit0_latency_in_9_12", (lat >= 9 && lat <= 12), 1);
    check("both_bit0_repeat_cnt", nrp[0], exp_rep);
    check("both_bit0_spacing_bad", bad_space, 0);

    // Reset in the middle of LONG with bit0 still high
    clr();
    lvl_a = 2'b01; step(20);
    check("rst_in_long_before", lheld_a[0], 1);
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      step(1);
      check("rst_outputs_zero", {press_a, rel_a, long_a, rep_a, held_a, lheld_a}, 0);
    end
    check("rst_no_release", nr[0], 0);
    rst = 1'b0;
    np[0] = 0; nl[0] = 0;
    step(1);
    check("rst_press_after_deassert", press_a, 2'b01);
    for (int g = 0; g < 14 && nl[0] == 0; g++) step(1);
    lat = long_cyc - press_cyc;
    check("rst_long_retimed_cnt", nl[0], 1);
    check("rst_long_latency_in_9_12", (lat >= 9 && lat <= 12), 1);
    lvl_a = 2'b00; step(3);

    // No-repeat instance: 60 cycles high
    clr();
    lvl_b = 1'b1; step(60);
    check("norep_lheld_before_rel", lheld_b[0], 1);
    lvl_b = 1'b0; step(2);
    check("norep_long_cnt", nlb, 1);
    check("norep_repeat_cnt", nrpb, 0);
    check("norep_release_cnt", nrb, 1);
    check("norep_lheld_after_rel", lheld_b[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
